// File: rtl/llc_pkg.sv
// Shared constants, state encoding and clamp helper for the LLC PWM generator.
// Optional soft-start ramp is enabled with LLC_PWM_SOFT_START_EN.
package llc_pkg;

  localparam logic [11:0] CNT_MIN     = 12'd416;
  localparam logic [11:0] CNT_MAX     = 12'd625;
  localparam logic [11:0] DEFAULT_CNT = 12'd520;
  localparam logic [11:0] SS_STEP     = 12'd16;
  localparam logic [7:0]  DEAD_CNT    = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FAULT
  } llc_state_e;

  function automatic logic [11:0] clamp_cnt(
    input logic [11:0] c
  );
    if (c < CNT_MIN)
      return CNT_MIN;
    else if (c > CNT_MAX)
      return CNT_MAX;
    else
      return c;
  endfunction

endpackage

// File: rtl/llc_pwm_gen_if.sv
// Control/status bundle between the voltage loop and the LLC gate-drive block.
// master = loop/controller side, slave = llc_pwm_gen.
interface llc_pwm_gen_if;

  logic        en;
  logic        fault;
  logic [11:0] freq_cnt;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_start;
  logic [11:0] period_cur;
  logic        fault_flag;

  modport master (
    output en,
    output fault,
    output freq_cnt,
    input  pwm_h,
    input  pwm_l,
    input  period_start,
    input  period_cur,
    input  fault_flag
  );

  modport slave (
    input  en,
    input  fault,
    input  freq_cnt,
    output pwm_h,
    output pwm_l,
    output period_start,
    output period_cur,
    output fault_flag
  );

endinterface

// File: rtl/llc_period_shadow.sv
// Period shadow register: clamps the command and loads it on start/wrap strobes.
// With LLC_PWM_SOFT_START_EN the first periods ramp down from CNT_MAX.
module llc_period_shadow
  import llc_pkg::*;
(
  input  logic        clk_50mhz,
  input  logic        rstn,
  input  logic        start,
  input  logic        wrap,
  input  logic [11:0] freq_cnt,
  output logic [11:0] p_nxt,
  output logic [11:0] p_cur
);

  logic [11:0] cmd;
  logic [11:0] p_q;
  logic [11:0] p_d;

  assign cmd   = clamp_cnt(freq_cnt);
  assign p_nxt = p_d;
  assign p_cur = p_q;

`ifdef LLC_PWM_SOFT_START_EN
  logic        ramp_q;
  logic        ramp_d;
  logic [11:0] step;

  assign step = p_q - SS_STEP;

  // Ramp only ever lowers P; a command at or above the next step ends it.
  always_comb begin
    p_d    = p_q;
    ramp_d = ramp_q;
    if (start) begin
      p_d    = CNT_MAX;
      ramp_d = (cmd < CNT_MAX);
    end else if (wrap) begin
      if (!ramp_q || step <= cmd) begin
        p_d    = cmd;
        ramp_d = 1'b0;
      end else begin
        p_d    = step;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn)
      ramp_q <= 1'b0;
    else
      ramp_q <= ramp_d;
  end
`else
  always_comb begin
    p_d = p_q;
    if (start || wrap)
      p_d = cmd;
  end
`endif

  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn)
      p_q <= DEFAULT_CNT;
    else
      p_q <= p_d;
  end

endmodule

// File: rtl/llc_pwm_gen.sv
// Complementary half-bridge PWM with dead time, period strobe and fault latch.
// Soft-start ramp selectable with LLC_PWM_SOFT_START_EN.
module llc_pwm_gen
  import llc_pkg::*;
(
  input  logic          clk_50mhz,
  input  logic          rstn,
  llc_pwm_gen_if.slave  bus
);

  llc_state_e  state_q;
  llc_state_e  state_d;
  logic [11:0] cnt_q;
  logic [11:0] cnt_d;
  logic        start;
  logic        wrap;
  logic        last;
  logic [11:0] p_nxt;
  logic [11:0] p_cur;

  logic        act_d;
  logic [11:0] dead;
  logic [11:0] half;
  logic        h_d;
  logic        l_d;
  logic        ps_d;
  logic        flag_d;

  logic        h_q;
  logic        l_q;
  logic        ps_q;
  logic        flag_q;

  llc_period_shadow u_shadow (
    .clk_50mhz (clk_50mhz),
    .rstn      (rstn),
    .start     (start),
    .wrap      (wrap),
    .freq_cnt  (bus.freq_cnt),
    .p_nxt     (p_nxt),
    .p_cur     (p_cur)
  );

  assign last = (cnt_q == p_cur - 12'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    wrap    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 12'd0;
        if (bus.fault) begin
          state_d = ST_FAULT;
        end else if (bus.en && !flag_q) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (bus.fault) begin
          state_d = ST_FAULT;
          cnt_d   = 12'd0;
        end else if (last) begin
          cnt_d = 12'd0;
          if (bus.en) begin
            state_d = ST_RUN;
            wrap    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 12'd1;
          state_d = bus.en ? ST_RUN : ST_DRAIN;
        end
      end
      ST_FAULT: begin
        cnt_d = 12'd0;
        if (!bus.en && !bus.fault)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_FAULT;
        cnt_d   = 12'd0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they line up with cnt_q.
  assign act_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign dead   = {4'd0, DEAD_CNT};
  assign half   = p_nxt >> 1;
  assign h_d    = act_d && (cnt_d >= dead) && (cnt_d < half);
  assign l_d    = act_d && (cnt_d >= half + dead) && (cnt_d < p_nxt);
  assign ps_d   = (state_d == ST_RUN) && (cnt_d == 12'd0);
  assign flag_d = (state_d == ST_FAULT);

  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 12'd0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
      ps_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      ps_q    <= ps_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.pwm_h        = h_q;
  assign bus.pwm_l        = l_q;
  assign bus.period_start = ps_q;
  assign bus.period_cur   = p_cur;
  assign bus.fault_flag   = flag_q;

endmodule

// File: tb/tb_llc_pwm_gen.sv
// Directed self-checking bench for llc_pwm_gen.
// Build with LLC_PWM_SOFT_START_EN to exercise the soft-start ramp instead.
module tb_llc_pwm_gen;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_pass;

  llc_pwm_gen_if bus ();

  llc_pwm_gen dut (
    .clk_50mhz (clk),
    .rstn      (rstn),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  // Starts on a negedge showing period_start; ends on the next one.
  task automatic meas(
    input  int          budget,
    input  int          chg_at,
    input  logic [11:0] chg_val,
    input  int          off_at,
    output int          len,
    output int          hc,
    output int          hf,
    output int          lc,
    output int          lf,
    output int          ov
  );
    int i;
    bit done;
    len = -1; hc = 0; hf = -1;
    lc = 0; lf = -1; ov = 0;
    i = 0; done = 1'b0;
    while (!done && i < budget) begin
      if (i > 0 && bus.period_start) begin
        len  = i;
        done = 1'b1;
      end else begin
        if (i == chg_at) bus.freq_cnt = chg_val;
        if (i == off_at) bus.en = 1'b0;
        if (bus.pwm_h) begin
          hc++;
          if (hf < 0) hf = i;
        end
        if (bus.pwm_l) begin
          lc++;
          if (lf < 0) lf = i;
        end
        if (bus.pwm_h && bus.pwm_l) ov++;
        @(negedge clk);
        i++;
      end
    end
  endtask

  int len, hc, hf, lc, lf, ov, seen;

`ifdef LLC_PWM_SOFT_START_EN
  int ss_exp [9] = '{625, 609, 593, 577, 561, 545, 529, 520, 520};
`endif

  initial begin
    n_chk = 0; n_pass = 0;
    rstn = 1'b0;
    bus.en = 1'b0;
    bus.fault = 1'b0;
    bus.freq_cnt = 12'd520;
    repeat (3) @(negedge clk);
    chk("rst_h", bus.pwm_h, 0);
    chk("rst_l", bus.pwm_l, 0);
    chk("rst_ps", bus.period_start, 0);
    chk("rst_pcur", bus.period_cur, 520);
    chk("rst_flag", bus.fault_flag, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ps", bus.period_start, 0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("start_lat", bus.period_start, 1);

`ifdef LLC_PWM_SOFT_START_EN
    foreach (ss_exp[k]) begin
      chk("ss_pcur", bus.period_cur, ss_exp[k]);
      meas(1000, -1, 12'd0, -1, len, hc, hf, lc, lf, ov);
      chk("ss_len", len, ss_exp[k]);
      chk("ss_ovl", ov, 0);
    end
`else
    // 520-cycle periods, 235-cycle halves with 25-cycle dead time
    chk("t1_pcur", bus.period_cur, 520);
    meas(1000, -1, 12'd0, -1, len, hc, hf, lc, lf, ov);
    chk("t1_len", len, 520);
    chk("t1_hcnt", hc, 235);
    chk("t1_hfirst", hf, 25);
    chk("t1_lcnt", lc, 235);
    chk("t1_lfirst", lf, 285);
    chk("t1_ovl", ov, 0);

    // clamp low then high; the change lands at the next wrap
    meas(1000, 0, 12'd300, -1, len, hc, hf, lc, lf, ov);
    chk("t2_len520", len, 520);
    chk("t2_pcur416", bus.period_cur, 416);
    meas(1000, 0, 12'd900, -1, len, hc, hf, lc, lf, ov);
    chk("t2_len416", len, 416);
    chk("t2_hcnt416", hc, 183);
    chk("t2_lcnt416", lc, 183);
    chk("t2_lfirst416", lf, 233);
    chk("t2_pcur625", bus.period_cur, 625);
    meas(1000, 0, 12'd520, -1, len, hc, hf, lc, lf, ov);
    chk("t2_len625", len, 625);
    chk("t2_hcnt625", hc, 287);
    chk("t2_lcnt625", lc, 288);
    chk("t2_lfirst625", lf, 337);
    chk("t2_ovl", ov, 0);

    // mid-period command change
    chk("t3_pcur520", bus.period_cur, 520);
    meas(1000, 100, 12'd600, -1, len, hc, hf, lc, lf, ov);
    chk("t3_len520", len, 520);
    chk("t3_pcur600", bus.period_cur, 600);
    meas(1000, 0, 12'd520, -1, len, hc, hf, lc, lf, ov);
    chk("t3_len600", len, 600);
    chk("t3_hcnt600", hc, 275);
    chk("t3_lcnt600", lc, 275);

    // drain: en drops at cnt 200
    chk("t4_pcur", bus.period_cur, 520);
    meas(700, -1, 12'd0, 200, len, hc, hf, lc, lf, ov);
    chk("t4_nostart", len, -1);
    chk("t4_hcnt", hc, 235);
    chk("t4_lcnt", lc, 235);
    chk("t4_lfirst", lf, 285);
    chk("t4_idle_h", bus.pwm_h, 0);
    chk("t4_idle_l", bus.pwm_l, 0);

    // fault at cnt 50
    bus.en = 1'b1;
    @(negedge clk);
    chk("t5_start", bus.period_start, 1);
    repeat (50) @(negedge clk);
    chk("t5_h_pre", bus.pwm_h, 1);
    bus.fault = 1'b1;
    @(negedge clk);
    chk("t5_h_off", bus.pwm_h, 0);
    chk("t5_l_off", bus.pwm_l, 0);
    chk("t5_flag", bus.fault_flag, 1);
    repeat (5) @(negedge clk);
    bus.fault = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.period_start || bus.pwm_h || bus.pwm_l) seen++;
    end
    chk("t5_stay_off", seen, 0);
    chk("t5_flag_hold", bus.fault_flag, 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("t5_flag_clr", bus.fault_flag, 0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("t5_restart", bus.period_start, 1);
    chk("t5_pcur", bus.period_cur, 520);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
